// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter for three requesters. Decodes the 8086 reg/w
// operand field into one-hot enables and sequences DX:AX double writes.
module regfile_write_arbiter #(
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [8:0]  reg_code,
    input  logic [2:0]  w,
    input  logic [2:0]  dbl,
    input  logic [2:0]  hi_src,
    input  logic [47:0] data,
    input  logic [47:0] data_hi,
    output logic [2:0]  ack,
    output logic [15:0] en_write,
    output logic [15:0] data_out,
    output logic        select_data_h_reg,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WR1, WR2} state_e;

    state_e      state_q, state_d;
    logic [1:0]  win_q, win_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [2:0]  ack_q, ack_d;
    logic [15:0] en_q, en_d;
    logic [15:0] dout_q, dout_d;
    logic        sel_q, sel_d;
    logic        busy_q, busy_d;

    logic [1:0]  pick;
    logic [2:0]  idx;

    // Per-requester fields; entry 3 is an unused zero pad so a 2-bit index is always in range.
    logic [2:0]  code_a [4];
    logic [15:0] data_a [4];
    logic [15:0] hi_a   [4];
    logic        w_a    [4];
    logic        dbl_a  [4];
    logic        hs_a   [4];

    assign code_a[0] = reg_code[2:0];
    assign code_a[1] = reg_code[5:3];
    assign code_a[2] = reg_code[8:6];
    assign code_a[3] = '0;
    assign data_a[0] = data[15:0];
    assign data_a[1] = data[31:16];
    assign data_a[2] = data[47:32];
    assign data_a[3] = '0;
    assign hi_a[0]   = data_hi[15:0];
    assign hi_a[1]   = data_hi[31:16];
    assign hi_a[2]   = data_hi[47:32];
    assign hi_a[3]   = '0;
    assign w_a[0]    = w[0];
    assign w_a[1]    = w[1];
    assign w_a[2]    = w[2];
    assign w_a[3]    = 1'b0;
    assign dbl_a[0]  = dbl[0];
    assign dbl_a[1]  = dbl[1];
    assign dbl_a[2]  = dbl[2];
    assign dbl_a[3]  = 1'b0;
    assign hs_a[0]   = hi_src[0];
    assign hs_a[1]   = hi_src[1];
    assign hs_a[2]   = hi_src[2];
    assign hs_a[3]   = 1'b0;

    function automatic logic [15:0] decode_en(input logic [2:0] code, input logic word);
        logic [3:0] pos;
        if (word) begin
            case (code)
                3'd0: pos = 4'd0;   // AX
                3'd1: pos = 4'd2;   // CX
                3'd2: pos = 4'd3;   // DX
                3'd3: pos = 4'd1;   // BX
                3'd4: pos = 4'd6;   // SP
                3'd5: pos = 4'd7;   // BP
                3'd6: pos = 4'd4;   // SI
                default: pos = 4'd5; // DI
            endcase
        end else begin
            case (code)
                3'd0: pos = 4'd12;  // AL
                3'd1: pos = 4'd14;  // CL
                3'd2: pos = 4'd15;  // DL
                3'd3: pos = 4'd13;  // BL
                3'd4: pos = 4'd8;   // AH
                3'd5: pos = 4'd10;  // CH
                3'd6: pos = 4'd11;  // DH
                default: pos = 4'd9; // BH
            endcase
        end
        return 16'h0001 << pos;
    endfunction

    // Winner selection; the round-robin loop scans from the farthest offset so the
    // nearest pending requester after the pointer is the last assignment.
    always_comb begin
        pick = 2'd0;
        idx  = '0;
        if (PRIO_MODE == 1) begin
            if (req[0])      pick = 2'd0;
            else if (req[1]) pick = 2'd1;
            else             pick = 2'd2;
        end else begin
            for (int unsigned k = 0; k < 3; k++) begin
                idx = {1'b0, ptr_q} + 3'(2 - k);
                if (idx >= 3'd3) idx = idx - 3'd3;
                if (req[idx[1:0]]) pick = idx[1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
        en_d    = '0;
        dout_d  = '0;
        sel_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    win_d   = pick;
                    ptr_d   = (pick == 2'd2) ? 2'd0 : pick + 2'd1;
                    state_d = WR1;
                    dout_d  = data_a[pick];
                    if (dbl_a[pick]) begin
                        en_d = 16'h0001;
                    end else begin
                        en_d  = decode_en(code_a[pick], w_a[pick]);
                        sel_d = !w_a[pick] && code_a[pick][2] && hs_a[pick];
                        ack_d = 3'b001 << pick;
                    end
                end
            end
            WR1: begin
                if (dbl_a[win_q]) begin
                    state_d = WR2;
                    en_d    = 16'h0008;
                    dout_d  = hi_a[win_q];
                    ack_d   = 3'b001 << win_q;
                end else begin
                    state_d = IDLE;
                end
            end
            WR2:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            win_q   <= '0;
            ptr_q   <= '0;
            ack_q   <= '0;
            en_q    <= '0;
            dout_q  <= '0;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            en_q    <= en_d;
            dout_q  <= dout_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    assign ack               = ack_q;
    assign en_write          = en_q;
    assign data_out          = dout_q;
    assign select_data_h_reg = sel_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized scoreboard bench: one round-robin and one fixed-priority arbiter,
// each checked cycle by cycle against a transaction-level model.
module tb_regfile_write_arbiter;

    typedef struct {
        logic [15:0] en;
        logic [15:0] d;
        logic [15:0] dh;
        logic        sel;
        logic        dbl;
    } txn_t;

    int checks = 0;
    int errors = 0;
    bit done0 = 1'b0;
    bit done1 = 1'b0;

    int wmap [8] = '{0, 2, 3, 1, 6, 7, 4, 5};
    int bmap [8] = '{12, 14, 15, 13, 8, 10, 11, 9};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d actual=%h required=%h t=%0t", nm, inst, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        logic        reset    = 1'b1;
        logic [2:0]  req      = '0;
        logic [8:0]  reg_code = '0;
        logic [2:0]  w        = '0;
        logic [2:0]  dbl      = '0;
        logic [2:0]  hi_src   = '0;
        logic [47:0] data     = '0;
        logic [47:0] data_hi  = '0;
        logic [2:0]  ack;
        logic [15:0] en_write;
        logic [15:0] data_out;
        logic        sel_h;
        logic        busy;
        txn_t        q [3][$];

        regfile_write_arbiter #(.PRIO_MODE(g)) dut (
            .clk(clk), .reset(reset), .req(req), .reg_code(reg_code), .w(w), .dbl(dbl),
            .hi_src(hi_src), .data(data), .data_hi(data_hi), .ack(ack), .en_write(en_write),
            .data_out(data_out), .select_data_h_reg(sel_h), .busy(busy)
        );

        task automatic issue(input int i, input bit fdbl);
            txn_t t;
            logic [2:0]  c;
            logic        wd, hs, db;
            logic [15:0] d0, d1;
            c  = 3'($urandom);
            wd = 1'($urandom);
            hs = 1'($urandom);
            d0 = 16'($urandom);
            d1 = 16'($urandom);
            db = fdbl || ($urandom_range(0, 3) == 0);
            reg_code[3*i +: 3] = c;
            w[i]      = wd;
            hi_src[i] = hs;
            dbl[i]    = db;
            data[16*i +: 16]    = d0;
            data_hi[16*i +: 16] = d1;
            t.en  = 16'(1) << (wd ? wmap[c] : bmap[c]);
            t.sel = !wd && c[2] && hs;
            t.d   = d0;
            t.dh  = d1;
            t.dbl = db;
            q[i].push_back(t);
            req[i] = 1'b1;
        endtask

        // Monitor: tracks which transaction the arbiter should be serving and pops on ack.
        initial begin : mon
            bit          tx;
            int          step, cur, ptr;
            txn_t        it;
            logic [15:0] e_en, e_d;
            logic        e_s;
            logic [2:0]  e_ack;
            tx = 0; step = 0; cur = 0; ptr = 0;
            forever begin
                @(negedge clk);
                if (reset) begin
                    chk("rst_en", g, 32'(en_write), 32'h0);
                    chk("rst_data", g, 32'(data_out), 32'h0);
                    chk("rst_ack", g, 32'(ack), 32'h0);
                    chk("rst_sel", g, 32'(sel_h), 32'h0);
                    chk("rst_busy", g, 32'(busy), 32'h0);
                    tx = 0; step = 0; ptr = 0;
                end else if (tx) begin
                    if (q[cur].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_empty inst%0d requester=%0d actual=empty required=pending", g, cur);
                        tx = 0;
                    end else begin
                        it = q[cur][0];
                        if (it.dbl && step == 0) begin
                            e_en = 16'h0001; e_d = it.d;  e_s = 1'b0;   e_ack = 3'b000;
                        end else if (it.dbl) begin
                            e_en = 16'h0008; e_d = it.dh; e_s = 1'b0;   e_ack = 3'(1 << cur);
                        end else begin
                            e_en = it.en;    e_d = it.d;  e_s = it.sel; e_ack = 3'(1 << cur);
                        end
                        chk("wr_en", g, 32'(en_write), 32'(e_en));
                        chk("wr_data", g, 32'(data_out), 32'(e_d));
                        chk("wr_sel", g, 32'(sel_h), 32'(e_s));
                        chk("wr_ack", g, 32'(ack), 32'(e_ack));
                        chk("wr_busy", g, 32'(busy), 32'h1);
                        if (e_ack != 3'b000) begin
                            void'(q[cur].pop_front());
                            tx = 0;
                        end else begin
                            step = 1;
                        end
                    end
                end else begin
                    chk("idle_en", g, 32'(en_write), 32'h0);
                    chk("idle_ack", g, 32'(ack), 32'h0);
                    chk("idle_busy", g, 32'(busy), 32'h0);
                    if (req != 3'b000) begin
                        if (g == 1) begin
                            cur = req[0] ? 0 : (req[1] ? 1 : 2);
                        end else begin
                            for (int k = 0; k < 3; k++) begin
                                if (req[(ptr + k) % 3]) begin
                                    cur = (ptr + k) % 3;
                                    break;
                                end
                            end
                            ptr = (cur + 1) % 3;
                        end
                        tx = 1;
                        step = 0;
                    end
                end
            end
        end

        // Requesters: random issue, hold until ack, drop on the edge ending the ack cycle.
        initial begin : drv
            logic [2:0] a;
            bit         got;
            repeat (2) @(negedge clk);
            @(posedge clk);
            #1 reset = 1'b0;
            for (int c = 0; c < 700; c++) begin
                @(negedge clk);
                a = ack;
                @(posedge clk);
                #1;
                for (int i = 0; i < 3; i++) begin
                    if (req[i]) begin
                        if (a[i]) req[i] = 1'b0;
                    end else if (c < 600 && $urandom_range(0, 2) == 0) begin
                        issue(i, 1'b0);
                    end
                end
            end
            chk("drain_req", g, 32'(req), 32'h0);
            chk("drain_q", g, 32'(q[0].size() + q[1].size() + q[2].size()), 32'h0);

            // Reset in the AX cycle of a double write, then the retry completes.
            @(posedge clk);
            #1 issue(2, 1'b1);
            @(posedge clk);
            @(negedge clk);
            #1 reset = 1'b1;
            #1;
            chk("async_rst_en", g, 32'(en_write), 32'h0);
            chk("async_rst_data", g, 32'(data_out), 32'h0);
            chk("async_rst_ack", g, 32'(ack), 32'h0);
            chk("async_rst_busy", g, 32'(busy), 32'h0);
            @(negedge clk);
            @(posedge clk);
            #1 reset = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                if (ack[2]) got = 1'b1;
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL retry_ack inst%0d actual=none required=ack[2] within 10 cycles", g);
            end
            @(posedge clk);
            #1 req[2] = 1'b0;
            repeat (3) @(posedge clk);
            if (g == 0) done0 = 1'b1;
            else        done1 = 1'b1;
        end
    end

    initial begin
        for (int t = 0; t < 3000 && !(done0 && done1); t++) @(posedge clk);
        if (!(done0 && done1)) begin
            errors++;
            $display("FAIL timeout actual=unfinished required=both benches done");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
